// File: rtl/stream_mux_rr.sv
// Registered N:1 valid/ready mux with fixed-select or round-robin arbitration; 1-cycle latency, full throughput.
// Stalls (all in_ready=0) while the held word is not accepted; `STREAM_MUX_PKT_LOCK_EN adds in_last/out_last packet locking.
module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef STREAM_MUX_PKT_LOCK_EN
  ,
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_last
`endif
);

  localparam int PAD = 1 << SEL_W;
  localparam logic [SEL_W:0] CH_LIM = CHANNELS[SEL_W:0];
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic [PAD-1:0]   valid_pad;
  logic [SEL_W-1:0] rr_grant, grant;
  logic             rr_ok, grant_ok, sel_ok;
  logic             load, xfer;
  logic [WIDTH-1:0] grant_data;

  // Pad to a power of two so any sel value indexes in range.
  always_comb begin
    valid_pad = '0;
    valid_pad[CHANNELS-1:0] = in_valid;
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    rr_grant = '0;
    rr_ok    = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      logic [SEL_W:0] cand;
      cand = {1'b0, last_q} + (SEL_W+1)'(k);
      if (cand >= CH_LIM) cand = cand - CH_LIM;
      if (!rr_ok && valid_pad[cand[SEL_W-1:0]]) begin
        rr_grant = cand[SEL_W-1:0];
        rr_ok    = 1'b1;
      end
    end
  end

  assign sel_ok = ({1'b0, sel} < CH_LIM);

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic           lock_q, lock_d;
  logic           out_last_q, out_last_d;
  logic [PAD-1:0] last_pad;

  always_comb begin
    last_pad = '0;
    last_pad[CHANNELS-1:0] = in_last;
  end
`endif

  always_comb begin
    grant    = rr_grant;
    grant_ok = rr_ok;
    if (!mode) begin
      grant    = sel;
      grant_ok = sel_ok & valid_pad[sel];
    end
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (lock_q) begin
      grant    = last_q;
      grant_ok = valid_pad[last_q];
    end
`endif
  end

  assign load = ~out_valid_q | out_ready;
  // No producer may see ready while reset is held.
  assign xfer = rst_n & load & grant_ok;
  assign in_ready = xfer ? (CHANNELS'(1) << grant) : '0;

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_d      = lock_q;
    out_last_d  = out_last_q;
`endif
    if (xfer) begin
      out_data_d  = grant_data;
      out_chan_d  = grant;
      out_valid_d = 1'b1;
      last_d      = grant;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_d      = ~last_pad[grant];
      out_last_d  = last_pad[grant];
`endif
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= LAST_RST;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q      <= 1'b0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q      <= lock_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr with 5 channels so that sel values 5..7 are out of range.
module tb_stream_mux_rr;
  localparam int W  = 8;
  localparam int CH = 5;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0] in_valid, in_ready;
  logic          mode;
  logic [SW-1:0] sel;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_chan;
  logic          out_valid, out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [CH-1:0] in_last;
  logic          out_last;
`endif

  int errors = 0;
  int checks = 0;

  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_chan, m_last;
  bit           m_lock, m_out_last;

  stream_mux_rr #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef STREAM_MUX_PKT_LOCK_EN
    , .in_last(in_last), .out_last(out_last)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_chan = 0; m_last = CH - 1; m_lock = 0; m_out_last = 0;
  endtask

  // Who would win arbitration given the model state and the inputs currently driven.
  function automatic void model_grant(output int g, output bit ok);
    g = 0; ok = 0;
    if (m_lock) begin
      g = m_last; ok = in_valid[m_last];
    end else if (mode == 1'b0) begin
      g = int'(sel);
      if (g < CH) ok = in_valid[g];
    end else begin
      for (int k = 1; k <= CH; k++) begin
        int i;
        i = (m_last + k) % CH;
        if (!ok && in_valid[i]) begin g = i; ok = 1; end
      end
    end
  endfunction

  function automatic logic [CH-1:0] exp_ready();
    int g; bit ok;
    model_grant(g, ok);
    if (rst_n && (!m_valid || out_ready) && ok) return CH'(1) << g;
    return '0;
  endfunction

  task automatic model_clock();
    int g; bit ok;
    if (!rst_n) begin
      model_reset();
      return;
    end
    model_grant(g, ok);
    if ((!m_valid || out_ready) && ok) begin
      m_data = in_data[g*W +: W]; m_chan = g; m_valid = 1; m_last = g;
`ifdef STREAM_MUX_PKT_LOCK_EN
      m_lock = !in_last[g]; m_out_last = in_last[g];
`endif
    end else if (!m_valid || out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < CH; i++) in_data[i*W +: W] = W'($urandom);
  endtask

  task automatic test_reset();
    logic [W-1:0] d0;
    rst_n = 0; mode = 1; sel = 0; in_valid = '1; out_ready = 1; rand_data();
`ifdef STREAM_MUX_PKT_LOCK_EN
    in_last = '1;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", out_data); end
    checks++; if (out_chan !== '0) begin errors++; $display("FAIL reset_chan: got %0d want 0", out_chan); end
    checks++; if (in_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    rst_n = 1;
    d0 = in_data[W-1:0];
    cycle();
    checks++; if (out_valid !== 1'b1 || out_chan !== 3'd0 || out_data !== d0) begin
      errors++; $display("FAIL reset_first: got v=%0b ch=%0d d=%0h want v=1 ch=0 d=%0h", out_valid, out_chan, out_data, d0);
    end
  endtask

  task automatic test_fixed_select();
    mode = 0; sel = 3'd2; in_valid = '1; out_ready = 1; rand_data();
    in_data[2*W +: W] = 8'hA5;
    #1;
    checks++; if (in_ready !== 5'b00100) begin errors++; $display("FAIL fixed_ready: got %b want 00100", in_ready); end
    cycle();
    checks++; if (out_valid !== 1'b1 || out_chan !== 3'd2 || out_data !== 8'hA5) begin
      errors++; $display("FAIL fixed_out: got v=%0b ch=%0d d=%0h want v=1 ch=2 d=a5", out_valid, out_chan, out_data);
    end
  endtask

  task automatic test_round_robin();
    int seq [6] = '{0, 1, 3, 0, 1, 3};
    mode = 0; sel = 3'd4; in_valid = '1; out_ready = 1; rand_data();
    cycle();
    mode = 1; in_valid = 5'b01011;
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] exp_d;
      rand_data();
      exp_d = in_data[seq[i]*W +: W];
      #1;
      checks++; if (in_ready !== (CH'(1) << seq[i])) begin errors++; $display("FAIL rr_ready[%0d]: got %b want ch %0d", i, in_ready, seq[i]); end
      cycle();
      checks++; if (out_valid !== 1'b1 || out_chan !== SW'(seq[i]) || out_data !== exp_d) begin
        errors++; $display("FAIL rr_out[%0d]: got ch=%0d d=%0h want ch=%0d d=%0h", i, out_chan, out_data, seq[i], exp_d);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held, d4;
    held = m_data;
    mode = 1; in_valid = '1; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      #1;
      checks++; if (in_ready !== '0) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0", i, in_ready); end
      cycle();
      checks++; if (out_valid !== 1'b1 || out_chan !== 3'd3 || out_data !== held) begin
        errors++; $display("FAIL stall_hold[%0d]: got v=%0b ch=%0d d=%0h want v=1 ch=3 d=%0h", i, out_valid, out_chan, out_data, held);
      end
    end
    out_ready = 1; rand_data();
    d4 = in_data[4*W +: W];
    #1;
    checks++; if (in_ready !== 5'b10000) begin errors++; $display("FAIL release_ready: got %b want 10000", in_ready); end
    cycle();
    checks++; if (out_valid !== 1'b1 || out_chan !== 3'd4 || out_data !== d4) begin
      errors++; $display("FAIL release_out: got v=%0b ch=%0d d=%0h want v=1 ch=4 d=%0h", out_valid, out_chan, out_data, d4);
    end
  endtask

  task automatic test_invalid_sel();
    logic [2:0] bad [2] = '{3'd5, 3'd7};
    mode = 0; in_valid = '1; out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      sel = bad[i]; rand_data();
      #1;
      checks++; if (in_ready !== '0) begin errors++; $display("FAIL badsel_ready[%0d]: got %b want 0", i, in_ready); end
      cycle();
      checks++; if (out_valid !== 1'b0 || out_chan !== 3'd4) begin
        errors++; $display("FAIL badsel_out[%0d]: got v=%0b ch=%0d want v=0 ch=4", i, out_valid, out_chan);
      end
    end
  endtask

  task automatic test_reset_mid();
    mode = 1; in_valid = '1; out_ready = 0; rand_data();
    cycle();
    rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_chan !== '0 || in_ready !== '0) begin
      errors++; $display("FAIL midreset: got v=%0b d=%0h ch=%0d rdy=%b want all 0", out_valid, out_data, out_chan, in_ready);
    end
    model_reset();
    cycle();
    rst_n = 1; out_ready = 1;
    cycle();
    checks++; if (out_valid !== 1'b1 || out_chan !== 3'd0) begin
      errors++; $display("FAIL midreset_restart: got v=%0b ch=%0d want v=1 ch=0", out_valid, out_chan);
    end
  endtask

`ifdef STREAM_MUX_PKT_LOCK_EN
  task automatic test_lock();
    logic [CH-1:0] lasts [4] = '{5'b11110, 5'b11110, 5'b11111, 5'b11111};
    int  exp_ch [4] = '{0, 0, 0, 1};
    bit  exp_l  [4] = '{0, 0, 1, 1};
    mode = 0; sel = 3'd4; in_valid = '1; in_last = '1; out_ready = 1; rand_data();
    cycle();
    in_valid = 5'b00011;
    for (int i = 0; i < 4; i++) begin
      mode = (i == 1) ? 1'b0 : 1'b1;
      sel = 3'd1; in_last = lasts[i]; rand_data();
      cycle();
      checks++; if (out_chan !== SW'(exp_ch[i]) || out_last !== exp_l[i] || out_valid !== 1'b1) begin
        errors++; $display("FAIL lock[%0d]: got ch=%0d last=%0b want ch=%0d last=%0b", i, out_chan, out_last, exp_ch[i], exp_l[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [CH-1:0] er;
      mode = 1'($urandom); sel = SW'($urandom_range(0, 7));
      in_valid = CH'($urandom); out_ready = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_PKT_LOCK_EN
      in_last = CH'($urandom);
`endif
      rand_data();
      er = exp_ready();
      #1;
      checks++; if (in_ready !== er) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", n, in_ready, er); end
      cycle();
      checks++; if (out_valid !== m_valid || out_data !== m_data || out_chan !== SW'(m_chan)) begin
        errors++; $display("FAIL rand_out[%0d]: got v=%0b d=%0h ch=%0d want v=%0b d=%0h ch=%0d",
                           n, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
      end
`ifdef STREAM_MUX_PKT_LOCK_EN
      checks++; if (out_last !== m_out_last) begin errors++; $display("FAIL rand_last[%0d]: got %0b want %0b", n, out_last, m_out_last); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fixed_select();
    test_round_robin();
    test_backpressure();
    test_invalid_sel();
    test_reset_mid();
`ifdef STREAM_MUX_PKT_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
